// File: rtl/encoder_pkg.sv
// Shared constants for the event encoder: arbitration modes and small helpers.
package encoder_pkg;

  localparam int FIXED       = 0;
  localparam int ROUND_ROBIN = 1;

  // Width of the round-robin pointer / channel index for n channels.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_encoder_prio_select.sv
// Combinational channel selector: highest pending index (fixed) or first
// pending index searching downward from ptr with wrap-around (round-robin).
module prio_select
  import encoder_pkg::*;
#(
  parameter int N  = 7,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic [PW-1:0] sel,
  output logic          any
);

  int          w_start;
  int          w_idx_i;
  logic [PW-1:0] w_idx;
  logic        w_hit;

  // Downward circular scan; the first hit wins and later hits are masked.
  always_comb begin
    sel     = {PW{1'b0}};
    any     = 1'b0;
    w_idx_i = 0;
    w_idx   = {PW{1'b0}};
    w_hit   = 1'b0;
    w_start = mode ? int'(ptr) : (N - 1);
    for (int k = 0; k < N; k++) begin
      w_idx_i = (w_start >= k) ? (w_start - k) : (w_start - k + N);
      w_idx   = PW'(w_idx_i);
      w_hit   = !any && req[w_idx];
      sel     = w_hit ? w_idx : sel;
      any     = any | req[w_idx];
    end
  end

endmodule

// File: rtl/event_encoder.sv
// Rising-edge event encoder: queues one pending bit per channel, arbitrates
// into a single registered output stage with valid/ready handshake.
module event_encoder
  import encoder_pkg::*;
#(
  parameter int N  = 7,
  parameter int W  = $clog2(N + 1),
  parameter int RR = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] evt_in,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic [N-1:0] ovf,
  input  logic         ovf_clr
);

  localparam int            PW       = idx_width(N);
  localparam logic [PW-1:0] PTR_INIT = PW'(N - 1);
  localparam logic          MODE     = (RR == ROUND_ROBIN) ? 1'b1 : 1'b0;

  logic [N-1:0]  r_evt_q;
  logic          r_armed;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_ovf;
  logic          r_out_valid;
  logic [W-1:0]  r_out_code;
  logic [PW-1:0] r_ptr;

  logic [N-1:0]  w_edge;
  logic          w_free;
  logic          w_any;
  logic          w_load;
  logic [PW-1:0] w_sel;
  logic [N-1:0]  w_clr;
  logic [N-1:0]  w_ovf_set;
  logic [W-1:0]  w_code;
  logic [PW-1:0] w_ptr_next;

  prio_select #(.N(N), .PW(PW)) u_sel (
    .req  (r_pending),
    .ptr  (r_ptr),
    .mode (MODE),
    .sel  (w_sel),
    .any  (w_any)
  );

  // The first edge after reset only primes evt_q, so levels held through reset are not events.
  assign w_edge     = r_armed ? (evt_in & ~r_evt_q) : {N{1'b0}};
  assign w_free     = ~r_out_valid | out_ready;
  assign w_load     = w_free & w_any;
  assign w_clr      = w_load ? ({{(N-1){1'b0}}, 1'b1} << w_sel) : {N{1'b0}};
  assign w_ovf_set  = w_edge & r_pending & ~w_clr;
  assign w_code     = W'(w_sel) + W'(1);
  assign w_ptr_next = (w_sel == {PW{1'b0}}) ? PTR_INIT : (w_sel - PW'(1));

  // Edge capture, pending/overflow bookkeeping, output stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_q     <= {N{1'b0}};
      r_armed     <= 1'b0;
      r_pending   <= {N{1'b0}};
      r_ovf       <= {N{1'b0}};
      r_out_valid <= 1'b0;
      r_out_code  <= {W{1'b0}};
      r_ptr       <= PTR_INIT;
    end else begin
      r_evt_q   <= evt_in;
      r_armed   <= 1'b1;
      r_pending <= (r_pending & ~w_clr) | w_edge;
      r_ovf     <= ovf_clr ? {N{1'b0}} : (r_ovf | w_ovf_set);
      if (w_free) begin
        r_out_valid <= w_any;
        r_out_code  <= w_any ? w_code : {W{1'b0}};
      end else begin
        r_out_valid <= r_out_valid;
        r_out_code  <= r_out_code;
      end
      if (w_load && MODE) begin
        r_ptr <= w_ptr_next;
      end else begin
        r_ptr <= r_ptr;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_code  = r_out_code;
  assign pending   = r_pending;
  assign ovf       = r_ovf;

endmodule
